// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Tracks pending register writes for the post-ID pipeline stages
//            and derives per-source forwarding selects, load-use stalls,
//            control-bubble insertion and PC / IF-ID load enables. A memory
//            freeze input holds the whole scoreboard while data memory is
//            busy.
// Revision : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
// Ports
//   CLK           in   clock, rising edge
//   CLR           in   asynchronous active-high reset
//   id_valid      in   ID holds a real instruction
//   id_src        in   NUM_SRC packed source register addresses
//   id_src_used   in   per-source "is read" flags
//   id_rd         in   destination register of the ID instruction
//   id_rf_en      in   ID instruction writes the register file
//   id_load       in   ID instruction is a load
//   flush         in   taken branch, squash the ID instruction
//   mem_busy      in   data memory not ready, freeze pipeline
//   fwd_sel       out  per-source select (0 = register file, k = stage k)
//   stall         out  load-use or freeze stall
//   nop_insert    out  force a control bubble into ID/EX
//   pc_en         out  PC load enable
//   ifid_le       out  IF/ID load enable
//   stall_cycles  out  (HAZ_STATS_EN only) saturating load-use stall count
//   freeze_cycles out  (HAZ_STATS_EN only) saturating freeze cycle count
// Optional : define HAZ_STATS_EN to add the two statistics counters.
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC    = 3,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_AVAIL = 2,
  parameter int PC_REG     = 15,
  localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
  input  logic                          CLK,
  input  logic                          CLR,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_rf_en,
  input  logic                          id_load,
  input  logic                          flush,
  input  logic                          mem_busy,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          stall,
  output logic                          nop_insert,
  output logic                          pc_en,
  output logic                          ifid_le
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0]                   stall_cycles,
  output logic [15:0]                   freeze_cycles
`endif
);

  localparam logic [REG_ADDR_W-1:0] C_PC_ADDR = REG_ADDR_W'(PC_REG);

  // Scoreboard entries; index 1 is ID/EX, index FWD_STAGES is the oldest.
  logic                  r_v    [1:FWD_STAGES];
  logic [REG_ADDR_W-1:0] r_rd   [1:FWD_STAGES];
  logic                  r_load [1:FWD_STAGES];

  logic [NUM_SRC-1:0]    w_lu_port;
  logic                  w_lu_hazard;

  // Per-source match search. Scanning oldest to youngest lets the youngest
  // producer overwrite, so both the select and the load-use flag reflect it.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_port
    logic [REG_ADDR_W-1:0] w_src;
    logic [SEL_W-1:0]      w_sel;
    logic                  w_lu;

    assign w_src = id_src[gi*REG_ADDR_W +: REG_ADDR_W];

    always_comb begin
      w_sel = '0;
      w_lu  = 1'b0;
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (id_src_used[gi] && r_v[k] && (r_rd[k] == w_src) &&
            (w_src != C_PC_ADDR)) begin
          w_sel = SEL_W'(k);
          w_lu  = r_load[k] && (k < LOAD_AVAIL);
        end
      end
    end

    assign fwd_sel[gi*SEL_W +: SEL_W] = w_sel;
    assign w_lu_port[gi]              = w_lu;
  end

  assign w_lu_hazard = id_valid && !flush && (|w_lu_port);

  // Control outputs. While CLR is held the pipeline sees reset values even if
  // a freeze request is still asserted.
  always_comb begin
    stall      = 1'b0;
    nop_insert = 1'b0;
    pc_en      = 1'b1;
    ifid_le    = 1'b1;
    if (!CLR) begin
      if (mem_busy) begin
        stall   = 1'b1;
        pc_en   = 1'b0;
        ifid_le = 1'b0;
      end else if (flush) begin
        nop_insert = 1'b1;
      end else if (w_lu_hazard) begin
        stall      = 1'b1;
        pc_en      = 1'b0;
        ifid_le    = 1'b0;
        nop_insert = 1'b1;
      end
    end
  end

  // Scoreboard shift. Flush and load-use both inject a bubble into stage 1.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        r_v[k]    <= 1'b0;
        r_rd[k]   <= '0;
        r_load[k] <= 1'b0;
      end
    end else if (!mem_busy) begin
      for (int k = FWD_STAGES; k >= 2; k--) begin
        r_v[k]    <= r_v[k-1];
        r_rd[k]   <= r_rd[k-1];
        r_load[k] <= r_load[k-1];
      end
      r_v[1]    <= id_valid && id_rf_en && !flush && !w_lu_hazard;
      r_rd[1]   <= id_rd;
      r_load[1] <= id_load;
    end
  end

`ifdef HAZ_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_freeze_cnt;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_stall_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      if (mem_busy && (r_freeze_cnt != 16'hFFFF)) begin
        r_freeze_cnt <= r_freeze_cnt + 16'd1;
      end
      // w_lu_hazard already excludes flush cycles.
      if (!mem_busy && w_lu_hazard && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign stall_cycles  = r_stall_cnt;
  assign freeze_cycles = r_freeze_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed self-checking bench for hazard_scoreboard with default
//            parameters (3 sources, 3 stages, loads forwardable from stage 2).
//            Observed vector layout: {sel2, sel1, sel0, stall, nop, pc_en,
//            ifid_le}; each select is 2 bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic        CLK;
  logic        CLR;
  logic        id_valid;
  logic [11:0] id_src;
  logic [2:0]  id_src_used;
  logic [3:0]  id_rd;
  logic        id_rf_en;
  logic        id_load;
  logic        flush;
  logic        mem_busy;
  logic [5:0]  fwd_sel;
  logic        stall;
  logic        nop_insert;
  logic        pc_en;
  logic        ifid_le;
`ifdef HAZ_STATS_EN
  logic [15:0] stall_cycles;
  logic [15:0] freeze_cycles;
`endif

  logic [9:0]  obs;
  logic [9:0]  exp_v;
  int          n_vec;
  int          n_err;

  assign obs = {fwd_sel, stall, nop_insert, pc_en, ifid_le};

  hazard_scoreboard dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_rd       (id_rd),
    .id_rf_en    (id_rf_en),
    .id_load     (id_load),
    .flush       (flush),
    .mem_busy    (mem_busy),
    .fwd_sel     (fwd_sel),
    .stall       (stall),
    .nop_insert  (nop_insert),
    .pc_en       (pc_en),
    .ifid_le     (ifid_le)
`ifdef HAZ_STATS_EN
    ,
    .stall_cycles  (stall_cycles),
    .freeze_cycles (freeze_cycles)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [2:0] used,
                        input logic [3:0] rd, input logic rf, input logic ld);
    id_valid    = v;
    id_src      = {s2, s1, s0};
    id_src_used = used;
    id_rd       = rd;
    id_rf_en    = rf;
    id_load     = ld;
    #1;
  endtask

  task automatic drain();
    flush    = 1'b0;
    mem_busy = 1'b0;
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    flush = 1'b0;
    mem_busy = 1'b0;
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0);
    #2;
    exp_v = {2'd0, 2'd0, 2'd0, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL reset_state: got %b expected %b", obs, exp_v);
    end
    tick();
    CLR = 1'b0;
    set_id(1'b1, 4'd1, 4'd2, 4'd0, 3'b011, 4'd3, 1'b1, 1'b0);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL empty_read_r1_r2: got %b expected %b", obs, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    drain();
    set_id(1'b1, 4'd1, 4'd2, 4'd0, 3'b011, 4'd3, 1'b1, 1'b0);  // ADD R3
    tick();
    set_id(1'b1, 4'd3, 4'd3, 4'd0, 3'b011, 4'd4, 1'b1, 1'b0);  // SUB R4,R3,R3
    exp_v = {2'd0, 2'd1, 2'd1, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL b2b_sel1: got %b expected %b", obs, exp_v);
    end
    tick();
    set_id(1'b1, 4'd0, 4'd0, 4'd3, 3'b100, 4'd9, 1'b0, 1'b0);  // reads R3 on port 2
    exp_v = {2'd2, 2'd0, 2'd0, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL b2b_sel2: got %b expected %b", obs, exp_v);
    end
    tick();
    set_id(1'b1, 4'd3, 4'd4, 4'd0, 3'b011, 4'd9, 1'b0, 1'b0);  // R3 at WB, R4 at MEM
    exp_v = {2'd0, 2'd2, 2'd3, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL b2b_sel3: got %b expected %b", obs, exp_v);
    end
    tick();
    set_id(1'b1, 4'd3, 4'd0, 4'd0, 3'b001, 4'd9, 1'b0, 1'b0);  // R3 retired
    exp_v = {2'd0, 2'd0, 2'd0, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL b2b_retired: got %b expected %b", obs, exp_v);
    end
  endtask

  task automatic test_load_use();
    drain();
    set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1, 1'b1);  // LDR R5
    tick();
    set_id(1'b1, 4'd5, 4'd1, 4'd0, 3'b011, 4'd6, 1'b1, 1'b0);  // ADD R6,R5,R1
    exp_v = {2'd0, 2'd0, 2'd1, 4'b1100};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL lu_stall: got %b expected %b", obs, exp_v);
    end
    tick();
    exp_v = {2'd0, 2'd0, 2'd2, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL lu_release: got %b expected %b", obs, exp_v);
    end
    tick();
    set_id(1'b1, 4'd5, 4'd6, 4'd0, 3'b011, 4'd9, 1'b0, 1'b0);  // ADD R6 at EX, LDR at WB
    exp_v = {2'd0, 2'd1, 2'd3, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL lu_after_bubble: got %b expected %b", obs, exp_v);
    end
    // Invalid ID slot behind a load: selects still computed, no stall.
    drain();
    set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b0, 4'd5, 4'd0, 4'd0, 3'b001, 4'd9, 1'b0, 1'b0);
    exp_v = {2'd0, 2'd0, 2'd1, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL lu_invalid_id: got %b expected %b", obs, exp_v);
    end
  endtask

  task automatic test_youngest();
    drain();
    set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1, 1'b1);  // LDR R5
    tick();
    set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1, 1'b0);  // MOV R5,#1
    exp_v = {2'd0, 2'd0, 2'd0, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL young_mov_no_src: got %b expected %b", obs, exp_v);
    end
    tick();
    set_id(1'b1, 4'd5, 4'd0, 4'd0, 3'b001, 4'd15, 1'b1, 1'b0);  // reads R5, writes R15
    exp_v = {2'd0, 2'd0, 2'd1, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL young_mov_wins: got %b expected %b", obs, exp_v);
    end
    tick();
    set_id(1'b1, 4'd15, 4'd5, 4'd15, 3'b111, 4'd9, 1'b0, 1'b0);
    exp_v = {2'd0, 2'd2, 2'd0, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL young_pc_never: got %b expected %b", obs, exp_v);
    end
    tick();
    set_id(1'b1, 4'd5, 4'd5, 4'd0, 3'b010, 4'd9, 1'b0, 1'b0);  // port 0 not used
    exp_v = {2'd0, 2'd3, 2'd0, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL young_unused_port: got %b expected %b", obs, exp_v);
    end
  endtask

  task automatic test_freeze();
    drain();
    #2 CLR = 1'b1;
    #1 CLR = 1'b0;
    set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1, 1'b1);  // LDR R5
    tick();
    set_id(1'b1, 4'd5, 4'd0, 4'd0, 3'b001, 4'd6, 1'b1, 1'b0);
    mem_busy = 1'b1;
    #1;
    exp_v = {2'd0, 2'd0, 2'd1, 4'b1000};
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL freeze_cycle%0d: got %b expected %b", c, obs, exp_v);
      end
      tick();
    end
    mem_busy = 1'b0;
    #1;
    exp_v = {2'd0, 2'd0, 2'd1, 4'b1100};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL freeze_then_lu: got %b expected %b", obs, exp_v);
    end
    tick();
    exp_v = {2'd0, 2'd0, 2'd2, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL freeze_release: got %b expected %b", obs, exp_v);
    end
`ifdef HAZ_STATS_EN
    n_vec++;
    if (freeze_cycles !== 16'd3) begin
      n_err++;
      $display("FAIL freeze_count: got %0d expected 3", freeze_cycles);
    end
    n_vec++;
    if (stall_cycles !== 16'd1) begin
      n_err++;
      $display("FAIL stall_count: got %0d expected 1", stall_cycles);
    end
`endif
  endtask

  task automatic test_flush();
    drain();
    set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1, 1'b1);  // LDR R5
    tick();
    set_id(1'b1, 4'd5, 4'd0, 4'd0, 3'b001, 4'd7, 1'b1, 1'b0);  // reader of R5, writes R7
    flush = 1'b1;
    #1;
    exp_v = {2'd0, 2'd0, 2'd1, 4'b0111};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL flush_with_lu: got %b expected %b", obs, exp_v);
    end
    tick();
    flush = 1'b0;
    set_id(1'b1, 4'd5, 4'd7, 4'd0, 3'b011, 4'd9, 1'b0, 1'b0);
    exp_v = {2'd0, 2'd0, 2'd2, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL flush_bubble: got %b expected %b", obs, exp_v);
    end
  endtask

  task automatic test_clr_mid_freeze();
    drain();
    set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1, 1'b1);  // LDR R5
    tick();
    set_id(1'b1, 4'd5, 4'd0, 4'd0, 3'b001, 4'd6, 1'b1, 1'b0);
    mem_busy = 1'b1;
    #1;
    exp_v = {2'd0, 2'd0, 2'd1, 4'b1000};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL clr_pre_freeze: got %b expected %b", obs, exp_v);
    end
    #1 CLR = 1'b1;
    #1;
    exp_v = {2'd0, 2'd0, 2'd0, 4'b0011};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL clr_async: got %b expected %b", obs, exp_v);
    end
    #1 CLR = 1'b0;
    mem_busy = 1'b0;
    #1;
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL clr_entries_gone: got %b expected %b", obs, exp_v);
    end
`ifdef HAZ_STATS_EN
    n_vec++;
    if (freeze_cycles !== 16'd0) begin
      n_err++;
      $display("FAIL clr_counters: got %0d expected 0", freeze_cycles);
    end
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_freeze();
    test_flush();
    test_clr_mid_freeze();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed 3-stage hazard/forwarding unit in the ARM pipeline top level.
- Tracks pending register writes in an internal scoreboard shift register, FWD_STAGES deep.
- Generates per-source-port forwarding selects, load-use stalls, NOP insertion and PC/IF-ID enables.
- Handles multi-cycle data memory through a freeze input. Sits in ID and drives the operand muxes, the CU NOP mux, the PC enable and the IF/ID load enable.

Parameters:
- REG_ADDR_W, 4: register address width.
- NUM_SRC, 3: number of ID source operand ports (Rn, Rm, Rd-as-source).
- FWD_STAGES, 3: number of post-ID stages that can forward (1=EX out, 2=MEM out, 3=WB).
- LOAD_AVAIL, 2: first stage index at which load data is forwardable. Range 1..FWD_STAGES.
- PC_REG, 15: register address never forwarded and never stalled on.

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*REG_ADDR_W  source register addresses; port i is at [i*REG_ADDR_W +: REG_ADDR_W].
- id_src_used  in  NUM_SRC  source i is actually read.
- id_rd  in  REG_ADDR_W  destination of the ID instruction.
- id_rf_en  in  1  ID instruction writes the register file.
- id_load  in  1  ID instruction is a load.
- flush  in  1  taken branch; squash the ID instruction.
- mem_busy  in  1  data memory not ready; freeze the pipeline.
- fwd_sel  out  NUM_SRC*SEL_W  per-port select. SEL_W = clog2(FWD_STAGES+1). 0 = register file, k = stage k.
- stall  out  1  load-use or freeze stall.
- nop_insert  out  1  force control bubble into ID/EX.
- pc_en  out  1  PC load enable.
- ifid_le  out  1  IF/ID load enable.

Behaviour:
- State: per stage k=1..FWD_STAGES holds {v, rd, load}. Stage 1 is ID/EX.
- Outputs are combinational from state and inputs. State updates on posedge CLK.
- Reset (CLR=1, asynchronous): all v=0. Resulting outputs: fwd_sel=0, stall=0, nop_insert=0, pc_en=1, ifid_le=1.
- match(i,k): id_src_used[i] & v[k] & rd[k]==src_i & src_i!=PC_REG.
- fwd_sel[i] = smallest k with match(i,k), else 0. The youngest producer wins.
- lu_hazard: id_valid & ~flush & there exists i,k with match(i,k), load[k], k<LOAD_AVAIL, and k is the youngest match for port i.
- Freeze (mem_busy=1):
  - stall=1, pc_en=0, ifid_le=0, nop_insert=0.
  - All stage entries hold.
  - flush is ignored; the requester must hold it until mem_busy drops.
- Else if flush=1:
  - stall=0, pc_en=1, ifid_le=1, nop_insert=1.
  - Shift; stage1 gets v=0.
- Else if lu_hazard:
  - stall=1, pc_en=0, ifid_le=0, nop_insert=1.
  - Shift; stage1 gets v=0 (bubble).
- Else:
  - stall=0, pc_en=1, ifid_le=1, nop_insert=0.
  - Shift; stage1 gets {id_valid&id_rf_en, id_rd, id_load}.
- Shift rule: stage k+1 <= stage k; stage FWD_STAGES is retired.
- Load-use stall length: exactly LOAD_AVAIL-k cycles for a producer in stage k. Default is 1 cycle behind an adjacent load.
- Writes to PC_REG are tracked but never matched. A source equal to PC_REG always gets sel 0.
- Same rd in several stages: the youngest wins, including when the youngest is a non-load and an older one is a load (no stall).
- CLR asserted mid-stall or mid-freeze clears all entries immediately. stall drops in the same cycle.

Optional Feature:
- Macro: HAZ_STATS_EN.
- With it defined, two extra outputs exist:
  - stall_cycles, 16 bits: counts cycles with lu_hazard & ~mem_busy & ~flush.
  - freeze_cycles, 16 bits: counts cycles with mem_busy=1.
  - Both saturate at 16'hFFFF and are cleared by CLR.
- Without it, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Reset, then ID reads R1,R2 with an empty scoreboard -> fwd_sel all 0, stall=0, pc_en=1, ifid_le=1.
- ADD R3 then SUB R4,R3,R3 back to back -> next cycle fwd_sel[0]=fwd_sel[1]=1, no stall. One cycle later a dependent reader gets sel=2, then sel=3.
- LDR R5, then immediately ADD R6,R5,R1 -> exactly 1 cycle stall=1, nop_insert=1, pc_en=0. Next cycle fwd_sel[0]=2, stall=0.
- LDR R5, then MOV R5,#1, then reader of R5 -> sel=1 (MOV, youngest), no stall. A reader of R15 with R15 pending -> sel=0.
- Load-use hazard with mem_busy held 3 cycles -> stall=1 and pc_en=0 for 3 cycles with scoreboard frozen, then 1 load-use stall cycle. With HAZ_STATS_EN: freeze_cycles=3, stall_cycles=1.
- flush=1 together with a load-use hazard -> stall=0, nop_insert=1, pc_en=1, stage1 bubble. CLR pulse mid-freeze -> all outputs return to reset values asynchronously.
